// File: rtl/stc_gamma_sequencer.sv
// stc_gamma_sequencer: gamma-cycle sequencer for a two-input pulse-width
// space-time compute unit. Per job: one local-reset cycle, one gamma of
// registered spike pulses, capture of the unit output's first rise time,
// then the result is held until the consumer handshakes it.
// Optional feature macro: STC_SEQ_WIDTH_MEASURE_EN (counts unit_y high cycles).

// Per-input pulse decode: high iff the input is live and t <= c < t+P.
// Compared in TW+1 bits so t+P never wraps; c never exceeds G-1 in RUN,
// so pulses running past the gamma end are clipped naturally.
module stc_gamma_sequencer_lane #(
    parameter int TW = 4,
    parameter int PW = 8
) (
    input  logic          en,
    input  logic [TW-1:0] t,
    input  logic          nul,
    input  logic [TW:0]   c,
    output logic          pulse
);
    logic [TW:0] t_beg;
    logic [TW:0] t_end;

    assign t_beg = {1'b0, t};
    assign t_end = t_beg + (TW+1)'(PW);
    assign pulse = en && !nul && (t_beg <= c) && (c < t_end);
endmodule

module stc_gamma_sequencer #(
    parameter  int GAMMA_CYCLE_WIDTH = 16,
    parameter  int PULSE_WIDTH       = 8,
    localparam int TW = $clog2(GAMMA_CYCLE_WIDTH),
    localparam int WW = $clog2(GAMMA_CYCLE_WIDTH+1)
) (
    input  logic          aclk,
    input  logic          grst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [TW-1:0] in_time_a,
    input  logic [TW-1:0] in_time_b,
    input  logic          in_null_a,
    input  logic          in_null_b,
    output logic          unit_rst,
    output logic          unit_a,
    output logic          unit_b,
    input  logic          unit_y,
    output logic          result_valid,
    input  logic          result_ready,
    output logic [TW-1:0] result_time,
    output logic          result_null,
    output logic [WW-1:0] result_width
);
    localparam int NUM_LANES = 2;
    localparam logic [TW-1:0] C_LAST = TW'(GAMMA_CYCLE_WIDTH-1);

    typedef enum logic [1:0] {IDLE, LRST, RUN, REPORT} state_t;

    typedef struct packed {
        logic [TW-1:0] t;
        logic          nul;
    } spike_t;

    state_t state, state_nxt;
    logic [TW-1:0] c;
    logic [TW:0]   c_nxt;
    spike_t [NUM_LANES-1:0] job;
    logic   [NUM_LANES-1:0] pulse_d;
    logic   [NUM_LANES-1:0] pulse_q;
    logic accept;
    logic unit_rst_d;
    logic run_nxt;

    assign accept = (state == IDLE) && in_valid;

    // state register
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = LRST;
            LRST:                      state_nxt = RUN;
            RUN:     if (c == C_LAST)  state_nxt = REPORT;
            REPORT:  if (result_ready) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // output decode: next values of the flopped unit drives, plus handshake flags
    always_comb begin
        unit_rst_d   = accept;
        run_nxt      = (state_nxt == RUN);
        c_nxt        = (state == LRST) ? '0 : ({1'b0, c} + 1'b1);
        in_ready     = (state == IDLE) && !grst;
        result_valid = (state == REPORT);
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        stc_gamma_sequencer_lane #(.TW(TW), .PW(PULSE_WIDTH)) u_lane (
            .en   (run_nxt),
            .t    (job[i].t),
            .nul  (job[i].nul),
            .c    (c_nxt),
            .pulse(pulse_d[i])
        );
    end

    assign unit_a = pulse_q[0];
    assign unit_b = pulse_q[1];

    // unit drives, gamma counter and job capture
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            unit_rst <= 1'b0;
            pulse_q  <= '0;
            c        <= '0;
            job      <= '0;
        end else begin
            unit_rst <= unit_rst_d;
            pulse_q  <= pulse_d;
            if (state == LRST || state == RUN) c <= c_nxt[TW-1:0];
            if (accept) begin
                job[0] <= '{t: in_time_a, nul: in_null_a};
                job[1] <= '{t: in_time_b, nul: in_null_b};
            end
        end
    end

    // first-rise capture; result_null stays set until a high sample is seen
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            result_time <= '0;
            result_null <= 1'b0;
        end else if (accept) begin
            result_time <= '0;
            result_null <= 1'b1;
        end else if (state == RUN && unit_y && result_null) begin
            result_time <= c;
            result_null <= 1'b0;
        end
    end

`ifdef STC_SEQ_WIDTH_MEASURE_EN
    logic [WW-1:0] wcnt;

    // high-sample counter, saturating at one full gamma
    always_ff @(posedge aclk or posedge grst) begin
        if (grst)
            wcnt <= '0;
        else if (accept)
            wcnt <= '0;
        else if (state == RUN && unit_y && wcnt != WW'(GAMMA_CYCLE_WIDTH))
            wcnt <= wcnt + 1'b1;
    end

    assign result_width = wcnt;
`else
    assign result_width = '0;
`endif
endmodule

// File: tb/tb_stc_gamma_sequencer.sv
// Bench for stc_gamma_sequencer with a behavioural temporal-max unit:
// the unit latches which inputs have risen (cleared by unit_rst) and drives
// y while both have risen and at least one is still high.
module tb_stc_gamma_sequencer;
    localparam int G  = 16;
    localparam int P  = 8;
    localparam int TW = 4;
    localparam int WW = 5;

    logic aclk, grst;
    logic in_valid, in_ready;
    logic [TW-1:0] in_time_a, in_time_b;
    logic in_null_a, in_null_b;
    logic unit_rst, unit_a, unit_b, unit_y;
    logic result_valid, result_ready;
    logic [TW-1:0] result_time;
    logic result_null;
    logic [WW-1:0] result_width;

    stc_gamma_sequencer #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(P)) dut (
        .aclk(aclk), .grst(grst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_time_a(in_time_a), .in_time_b(in_time_b),
        .in_null_a(in_null_a), .in_null_b(in_null_b),
        .unit_rst(unit_rst), .unit_a(unit_a), .unit_b(unit_b), .unit_y(unit_y),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_time(result_time), .result_null(result_null),
        .result_width(result_width)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // temporal-max unit model
    logic sa, sb;
    always @(posedge aclk or posedge grst) begin
        if (grst || unit_rst) begin
            sa <= 1'b0;
            sb <= 1'b0;
        end else begin
            sa <= sa | unit_a;
            sb <= sb | unit_b;
        end
    end
    assign unit_y = (sa | unit_a) & (sb | unit_b) & (unit_a | unit_b);

    typedef struct {
        logic [TW-1:0] ta, tb;
        logic          na, nb;
        logic [TW-1:0] et;
        logic          en;
        logic [WW-1:0] ew;
        int            stall;
        logic          early;
    } vec_t;

    typedef struct {
        logic [TW-1:0] et;
        logic          en;
        logic [WW-1:0] ew;
    } res_t;

    res_t sb_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic exp_pulse(input logic [TW-1:0] t, input logic n, input int c);
        return !n && (int'(t) <= c) && (c < int'(t) + P);
    endfunction

    function automatic logic [WW-1:0] eff_w(input logic [WW-1:0] w);
`ifdef STC_SEQ_WIDTH_MEASURE_EN
        return w;
`else
        return w & '0;
`endif
    endfunction

    // wait in IDLE (bounded), issue one job, follow it through to the handshake
    task automatic run_job(input vec_t v);
        int k, bad;
        res_t r;
        logic [TW-1:0] h_time;
        logic h_null;
        logic [WW-1:0] h_w;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge aclk);
            k++;
        end
        chk("idle_ready", in_ready, 1);
        if (!in_ready) return;
        in_time_a = v.ta; in_time_b = v.tb;
        in_null_a = v.na; in_null_b = v.nb;
        in_valid = 1'b1;
        if (v.early) result_ready = 1'b1;
        sb_q.push_back('{et: v.et, en: v.en, ew: eff_w(v.ew)});
        @(posedge aclk);
        #1 in_valid = 1'b0;
        @(negedge aclk);
        chk("lrst_drive", {unit_rst, unit_a, unit_b, in_ready}, 4'b1000);
        bad = 0;
        for (int c = 0; c < G; c++) begin
            @(negedge aclk);
            if (unit_a !== exp_pulse(v.ta, v.na, c)) bad++;
            if (unit_b !== exp_pulse(v.tb, v.nb, c)) bad++;
            if (unit_rst !== 1'b0 || result_valid !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        chk("run_pulses", bad, 0);
        @(negedge aclk);
        chk("latency_valid", result_valid, 1);
        h_time = result_time; h_null = result_null; h_w = result_width;
        bad = 0;
        for (int s = 0; s < v.stall; s++) begin
            in_valid = 1'b1;
            in_time_a = ~v.ta; in_null_a = ~v.na;
            @(negedge aclk);
            if (result_valid !== 1'b1 || in_ready !== 1'b0) bad++;
            if (result_time !== h_time || result_null !== h_null || result_width !== h_w) bad++;
        end
        if (v.stall > 0) chk("stall_stable", bad, 0);
        result_ready = 1'b1;
        r = sb_q.pop_front();
        chk("result_time", result_time, r.et);
        chk("result_null", result_null, r.en);
        chk("result_width", result_width, r.ew);
        @(posedge aclk);
        #1;
        result_ready = 1'b0;
        in_valid = 1'b0;
        @(negedge aclk);
        chk("ready_after_hs", {in_ready, result_valid}, 2'b10);
    endtask

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{ta: 2,  tb: 5,  na: 0, nb: 0, et: 5,  en: 0, ew: 8, stall: 0, early: 0};
        tbl[1] = '{ta: 3,  tb: 3,  na: 0, nb: 0, et: 3,  en: 0, ew: 8, stall: 0, early: 0};
        tbl[2] = '{ta: 4,  tb: 0,  na: 0, nb: 1, et: 0,  en: 1, ew: 0, stall: 0, early: 0};
        tbl[3] = '{ta: 12, tb: 12, na: 0, nb: 0, et: 12, en: 0, ew: 4, stall: 5, early: 0};
        tbl[4] = '{ta: 0,  tb: 15, na: 0, nb: 0, et: 15, en: 0, ew: 1, stall: 0, early: 1};
        tbl[5] = '{ta: 7,  tb: 1,  na: 0, nb: 0, et: 7,  en: 0, ew: 8, stall: 2, early: 0};
        tbl[6] = '{ta: 14, tb: 0,  na: 0, nb: 0, et: 14, en: 0, ew: 2, stall: 0, early: 0};
        tbl[7] = '{ta: 0,  tb: 0,  na: 1, nb: 1, et: 0,  en: 1, ew: 0, stall: 0, early: 0};
        tbl[8] = '{ta: 5,  tb: 9,  na: 1, nb: 0, et: 0,  en: 1, ew: 0, stall: 0, early: 0};

        grst = 1'b1; in_valid = 1'b1; result_ready = 1'b0;
        in_time_a = 0; in_time_b = 0; in_null_a = 0; in_null_b = 0;
        repeat (3) @(negedge aclk);
        chk("reset_ready", in_ready, 0);
        chk("reset_unit", {unit_rst, unit_a, unit_b}, 0);
        chk("reset_result", {result_valid, result_time, result_null, result_width}, 0);
        in_valid = 1'b0;
        grst = 1'b0;
        #1 chk("ready_on_release", in_ready, 1);

        for (int i = 0; i < 9; i++) run_job(tbl[i]);

        // reset mid-run at c=6: job discarded, outputs back to reset values
        @(negedge aclk);
        in_time_a = 2; in_time_b = 5; in_null_a = 0; in_null_b = 0;
        in_valid = 1'b1;
        @(posedge aclk);
        #1 in_valid = 1'b0;
        repeat (8) @(negedge aclk);
        chk("c6_pulse_a", unit_a, 1);
        grst = 1'b1;
        #1;
        chk("midrst_unit", {unit_rst, unit_a, unit_b, in_ready}, 0);
        chk("midrst_result", {result_valid, result_time, result_null, result_width}, 0);
        @(negedge aclk);
        grst = 1'b0;
        #1 chk("midrst_release_ready", in_ready, 1);
        run_job('{ta: 1, tb: 1, na: 0, nb: 0, et: 1, en: 0, ew: 8, stall: 0, early: 0});

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
